peg_l2_rs_xmii_tx: RTL and testbench
====================================

PEG_L2_RS_XMII_TX -- requirements
Module: peg_l2_rs_xmii_tx

Interface
REQ-001 SHALL have parameter PKT_DATA_W, default 8: packet byte width; only 8 is legal.
REQ-002 SHALL have parameter PHY_DATA_W, default 2: PHY lane width; 2 selects RMII, 4 selects MII nibble mode; other values are illegal.
REQ-003 SHALL have parameter IPG_BYTES, default 12: minimum inter-packet gap in byte times, legal range 1..63.
REQ-004 SHALL have port xmii_ref_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port config_rs_mii_speed_100_n_10, input, 1 bit: 1 selects 100 Mb/s, 0 selects 10 Mb/s.
REQ-007 SHALL have ports pkt_tx_valid, pkt_tx_sop and pkt_tx_eop, inputs, 1 bit each: the slave packet stream.
REQ-008 SHALL have port pkt_tx_data, input, PKT_DATA_W bits: the packet byte.
REQ-009 SHALL have port pkt_tx_ready, output, 1 bit: a byte is accepted in any cycle where valid and ready are both high.
REQ-010 SHALL have port xmii_txd, output, PHY_DATA_W bits: transmit data to the PHY.
REQ-011 SHALL have port xmii_tx_en, output, 1 bit: transmit enable to the PHY.
REQ-012 SHALL have port tx_underrun, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-013 SHALL have port tx_frame_cnt, output, 16 bits: count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-014 SHALL implement FSM states IDLE, PREAMBLE, SFD, DATA, DROP and IPG.
REQ-015 In IDLE, ready SHALL be 1 for non-SOP beats, which are discarded; ready SHALL be 0 when valid and sop are both high, and the FSM SHALL move to PREAMBLE.
REQ-016 PREAMBLE SHALL send 7 bytes of 0x55; SFD SHALL send 1 byte of 0xD5; xmii_tx_en SHALL rise 1 cycle after the SOP is detected.
REQ-017 Each byte SHALL be serialised LSB-first as 8/PHY_DATA_W lane symbols.
REQ-018 Each lane symbol SHALL be held for 1 cycle at 100 Mb/s and for 10 cycles at 10 Mb/s.
REQ-019 The speed setting SHALL be sampled only on the IDLE-to-PREAMBLE transition and held for the whole frame.
REQ-020 pkt_tx_ready SHALL be high only on the final cycle of the final symbol of the current byte, in SFD or DATA.
REQ-021 An accepted byte SHALL start on xmii_txd in the next cycle, with no bubbles.
REQ-022 An accepted byte with eop=1 SHALL be fully sent; the FSM SHALL then enter IPG, deassert xmii_tx_en and increment tx_frame_cnt.
REQ-023 If ready is high, valid is low and DATA is active (underrun), the block SHALL deassert xmii_tx_en next cycle, pulse tx_underrun and enter DROP; tx_frame_cnt SHALL NOT increment.
REQ-024 DROP SHALL hold ready=1 and discard beats up to and including eop, then enter IPG.
REQ-025 A beat with sop=1 arriving in DATA or DROP SHALL be treated as an implicit end of frame: abort and pulse tx_underrun if in DATA, then enter IPG without consuming the beat.
REQ-026 IPG SHALL hold xmii_tx_en=0 and xmii_txd=0 for IPG_BYTES×(8/PHY_DATA_W)×(1 or 10) cycles, then enter IDLE.
REQ-027 xmii_txd SHALL be 0 whenever xmii_tx_en is 0.
REQ-028 xmii_txd and xmii_tx_en SHALL be registered outputs.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in IDLE, all counters SHALL be 0, and xmii_tx_en, xmii_txd, pkt_tx_ready, tx_underrun and tx_frame_cnt SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL truncate the frame immediately, and the block SHALL NOT emit an underrun pulse.
REQ-031 After release, ready SHALL follow REQ-015 from the first clock edge.

Structure
REQ-032 The FSM state enum and the constants PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5), PREAMBLE_LEN (7) and SPEED10_REPL (10) SHALL live in package peg_l2_rs_pkg.
REQ-033 A single sub-module, peg_l2_rs_ser (byte-to-lane serialiser with replication counter, parametrised by PHY_DATA_W), SHALL be instantiated.
REQ-034 The block SHALL be drop-in for the TX side of the RS wrapper, using the same pkt_intf port macros.

Verification
REQ-035 PHY_DATA_W=2 at 100 Mb/s, 4-byte frame 0x01..0x04 -> 28 dibits of 01, then dibits 01,01,01,11, then 16 data dibits LSB-first, xmii_tx_en high 48 cycles, then 48 idle IPG cycles, tx_frame_cnt=1.
REQ-036 PHY_DATA_W=2 at 10 Mb/s, same frame -> xmii_tx_en high 480 cycles, each dibit constant for 10 cycles.
REQ-037 PHY_DATA_W=4 at 100 Mb/s, 1-byte frame 0xA5 -> 14 nibbles of 5, then nibbles 5,D, then nibbles 5,A, xmii_tx_en high 18 cycles.
REQ-038 valid dropped for 1 cycle after byte 2 of a 6-byte frame -> tx_en falls next cycle, tx_underrun single pulse, remaining bytes drained up to eop, tx_frame_cnt unchanged.
REQ-039 Speed toggled mid-frame -> frame finishes at the original speed; next frame uses the new speed.
REQ-040 Reset at byte 3 of a frame, then back-to-back frames with tx_frame_cnt preset near 0xFFFF -> all outputs 0 during reset; the counter wraps to 0 and the IPG is honoured exactly.

Source files
------------

// File: rtl/peg_l2_rs_pkg.sv
// Shared types and constants for the RS xMII transmit path.
package peg_l2_rs_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_DROP,
    S_IPG
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;
  localparam int         SPEED10_REPL  = 10;

  // Gap length in clock cycles for a given lane width and speed.
  function automatic int ipg_cycles(input int ipg_bytes, input int phy_w, input logic slow);
    return ipg_bytes * (8 / phy_w) * (slow ? SPEED10_REPL : 1);
  endfunction

endpackage

// File: rtl/peg_l2_rs_ser.sv
// Byte-to-lane serialiser: LSB-first symbols, each held 1 or SPEED10_REPL cycles.
module peg_l2_rs_ser
  import peg_l2_rs_pkg::*;
#(
  parameter int PHY_DATA_W = 2
) (
  input  logic                  xmii_ref_clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [7:0]            load_data,
  input  logic                  slow,
  output logic [PHY_DATA_W-1:0] txd,
  output logic                  tx_en,
  output logic                  last
);

  localparam int         SYMS          = 8 / PHY_DATA_W;
  localparam logic [2:0] SYM_LAST      = 3'(SYMS - 1);
  localparam logic [3:0] REP_LAST_SLOW = 4'(SPEED10_REPL - 1);

  logic [7:0] shreg;
  logic [2:0] sym_cnt;
  logic [3:0] rep_cnt;
  logic [3:0] rep_reload;
  logic       active;

  assign rep_reload = slow ? REP_LAST_SLOW : 4'd0;
  // Final cycle of the final symbol: the only point where a new byte may be loaded.
  assign last  = active && (sym_cnt == 3'd0) && (rep_cnt == 4'd0);
  assign tx_en = active;

  always_ff @(posedge xmii_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      sym_cnt <= '0;
      rep_cnt <= '0;
      active  <= 1'b0;
      txd     <= '0;
    end else if (load) begin
      active  <= 1'b1;
      txd     <= load_data[PHY_DATA_W-1:0];
      shreg   <= load_data >> PHY_DATA_W;
      sym_cnt <= SYM_LAST;
      rep_cnt <= rep_reload;
    end else if (active) begin
      if (rep_cnt != 4'd0) begin
        rep_cnt <= rep_cnt - 4'd1;
      end else if (sym_cnt != 3'd0) begin
        txd     <= shreg[PHY_DATA_W-1:0];
        shreg   <= shreg >> PHY_DATA_W;
        sym_cnt <= sym_cnt - 3'd1;
        rep_cnt <= rep_reload;
      end else begin
        active <= 1'b0;
        txd    <= '0;
      end
    end
  end

endmodule

// File: rtl/peg_l2_rs_xmii_tx.sv
// RS transmit side: packet stream to RMII/MII lanes with preamble, SFD, underrun abort and IPG.
//   state      | meaning
//   S_IDLE     | discard non-SOP beats, wait for SOP (held, not consumed)
//   S_PREAMBLE | sending PREAMBLE_LEN bytes of 0x55
//   S_SFD      | sending 0xD5, first data byte accepted on its last cycle
//   S_DATA     | sending packet bytes back-to-back
//   S_DROP     | after abort, discard beats up to eop
//   S_IPG      | line idle for the inter-packet gap
module peg_l2_rs_xmii_tx
  import peg_l2_rs_pkg::*;
#(
  parameter int PKT_DATA_W = 8,
  parameter int PHY_DATA_W = 2,
  parameter int IPG_BYTES  = 12
) (
  input  logic                  xmii_ref_clk,
  input  logic                  rst_n,
  input  logic                  config_rs_mii_speed_100_n_10,
  input  logic                  pkt_tx_valid,
  input  logic                  pkt_tx_sop,
  input  logic                  pkt_tx_eop,
  input  logic [PKT_DATA_W-1:0] pkt_tx_data,
  output logic                  pkt_tx_ready,
  output logic [PHY_DATA_W-1:0] xmii_txd,
  output logic                  xmii_tx_en,
  output logic                  tx_underrun,
  output logic [15:0]           tx_frame_cnt
);

  localparam logic [11:0] IPG_LAST_FAST = 12'(ipg_cycles(IPG_BYTES, PHY_DATA_W, 1'b0) - 1);
  localparam logic [11:0] IPG_LAST_SLOW = 12'(ipg_cycles(IPG_BYTES, PHY_DATA_W, 1'b1) - 1);
  localparam logic [11:0] PRE_LAST      = 12'(PREAMBLE_LEN - 1);

  tx_state_t   state, state_n;
  logic [11:0] cnt, cnt_n;
  logic        slow_q, slow_n;
  logic        eop_q, eop_n;
  logic [15:0] frame_cnt_q;
  logic        underrun_q;

  logic        ready_c;
  logic        ser_load;
  logic [7:0]  ser_byte;
  logic        ser_slow;
  logic        ser_last;
  logic        frame_inc;
  logic        underrun_c;
  logic        sop_beat;
  logic [11:0] ipg_last;

  assign sop_beat = pkt_tx_valid && pkt_tx_sop;
  assign ipg_last = slow_q ? IPG_LAST_SLOW : IPG_LAST_FAST;

  peg_l2_rs_ser #(.PHY_DATA_W(PHY_DATA_W)) u_ser (
    .xmii_ref_clk (xmii_ref_clk),
    .rst_n        (rst_n),
    .load         (ser_load),
    .load_data    (ser_byte),
    .slow         (ser_slow),
    .txd          (xmii_txd),
    .tx_en        (xmii_tx_en),
    .last         (ser_last)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    slow_n     = slow_q;
    eop_n      = eop_q;
    ready_c    = 1'b0;
    ser_load   = 1'b0;
    ser_byte   = PREAMBLE_BYTE;
    ser_slow   = slow_q;
    frame_inc  = 1'b0;
    underrun_c = 1'b0;
    case (state)
      S_IDLE: begin
        // Speed is latched here and frozen for the rest of the frame.
        ser_slow = !config_rs_mii_speed_100_n_10;
        ready_c  = !sop_beat;
        if (sop_beat) begin
          state_n  = S_PREAMBLE;
          cnt_n    = PRE_LAST;
          slow_n   = ser_slow;
          eop_n    = 1'b0;
          ser_load = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (ser_last) begin
          ser_load = 1'b1;
          if (cnt == 12'd0) begin
            ser_byte = SFD_BYTE;
            state_n  = S_SFD;
          end else begin
            cnt_n = cnt - 12'd1;
          end
        end
      end
      S_SFD: begin
        // The SOP beat held since IDLE is the first data byte.
        if (ser_last) begin
          ready_c = 1'b1;
          if (pkt_tx_valid) begin
            ser_load = 1'b1;
            ser_byte = pkt_tx_data[7:0];
            eop_n    = pkt_tx_eop;
            state_n  = S_DATA;
          end else begin
            underrun_c = 1'b1;
            state_n    = S_DROP;
          end
        end
      end
      S_DATA: begin
        if (ser_last) begin
          if (eop_q) begin
            frame_inc = 1'b1;
            state_n   = S_IPG;
            cnt_n     = ipg_last;
          end else begin
            ready_c = !sop_beat;
            if (sop_beat) begin
              underrun_c = 1'b1;
              state_n    = S_IPG;
              cnt_n      = ipg_last;
            end else if (pkt_tx_valid) begin
              ser_load = 1'b1;
              ser_byte = pkt_tx_data[7:0];
              eop_n    = pkt_tx_eop;
            end else begin
              underrun_c = 1'b1;
              state_n    = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        ready_c = !sop_beat;
        if (sop_beat || (pkt_tx_valid && pkt_tx_eop)) begin
          state_n = S_IPG;
          cnt_n   = ipg_last;
        end
      end
      S_IPG: begin
        if (cnt == 12'd0) state_n = S_IDLE;
        else              cnt_n   = cnt - 12'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge xmii_ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      slow_q      <= 1'b0;
      eop_q       <= 1'b0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      slow_q     <= slow_n;
      eop_q      <= eop_n;
      underrun_q <= underrun_c;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign pkt_tx_ready = rst_n & ready_c;
  assign tx_underrun  = underrun_q;
  assign tx_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_peg_l2_rs_xmii_tx.sv
// Bench for peg_l2_rs_xmii_tx: RMII and MII instances against a symbol-stream model.
module tb_peg_l2_rs_xmii_tx;

  localparam int IPG = 12;

  typedef struct {
    int               k;
    bit               slow;
    int               nb;
    int               hole;
    int               en_len;
    int               ur_exp;
    logic [7:0][7:0]  b;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             spd;
  logic [1:0]       v, so, eo;
  logic [1:0][7:0]  d;
  logic [1:0]       rdy, en, ur;
  logic             rdy0, rdy1, en0, en1, ur0, ur1;
  logic [1:0]       txd2;
  logic [3:0]       txd4;
  logic [15:0]      fc0, fc1;

  int               total = 0;
  int               bad = 0;
  int unsigned      got[2][$];
  int unsigned      exp_q[$];
  int               gaps[2][$];
  int               fcs[2][$];
  int               low_run[2];
  int               uc[2];
  int               exp_cnt[2];
  int               zviol = 0;
  logic [1:0]       en_prev = '0;
  vec_t             vt[14];

  always #5 clk = ~clk;

  assign rdy = {rdy1, rdy0};
  assign en  = {en1, en0};
  assign ur  = {ur1, ur0};

  peg_l2_rs_xmii_tx #(.PHY_DATA_W(2)) dut2 (
    .xmii_ref_clk(clk), .rst_n(rst_n), .config_rs_mii_speed_100_n_10(spd),
    .pkt_tx_valid(v[0]), .pkt_tx_sop(so[0]), .pkt_tx_eop(eo[0]), .pkt_tx_data(d[0]),
    .pkt_tx_ready(rdy0), .xmii_txd(txd2), .xmii_tx_en(en0), .tx_underrun(ur0), .tx_frame_cnt(fc0));

  peg_l2_rs_xmii_tx #(.PHY_DATA_W(4)) dut4 (
    .xmii_ref_clk(clk), .rst_n(rst_n), .config_rs_mii_speed_100_n_10(spd),
    .pkt_tx_valid(v[1]), .pkt_tx_sop(so[1]), .pkt_tx_eop(eo[1]), .pkt_tx_data(d[1]),
    .pkt_tx_ready(rdy1), .xmii_txd(txd4), .xmii_tx_en(en1), .tx_underrun(ur1), .tx_frame_cnt(fc1));

  // Line monitor: symbol capture, gap lengths, counter snapshot at frame start, underrun pulses.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (en[k]) begin
        got[k].push_back(k == 0 ? int'(txd2) : int'(txd4));
        if (!en_prev[k]) begin
          gaps[k].push_back(low_run[k]);
          fcs[k].push_back(k == 0 ? int'(fc0) : int'(fc1));
        end
        low_run[k] = 0;
      end else begin
        low_run[k]++;
      end
      if (ur[k]) uc[k]++;
    end
    if (!en0 && txd2 != 2'd0) zviol++;
    if (!en1 && txd4 != 4'd0) zviol++;
    en_prev = en;
  end

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int ipg_len(input int w, input bit slow);
    return IPG * (8 / w) * (slow ? 10 : 1);
  endfunction

  // Reference: every byte of preamble, SFD and sent data, split LSB-first, each symbol repeated.
  function automatic void build_exp(input int w, input bit slow, input int sent, input logic [7:0][7:0] b);
    int reps = slow ? 10 : 1;
    for (int i = 0; i < 8 + sent; i++) begin
      int bt = (i < 7) ? 'h55 : (i == 7) ? 'hD5 : int'(b[i-8]);
      for (int s = 0; s < 8 / w; s++) begin
        int unsigned sym = (bt >> (s * w)) & ((1 << w) - 1);
        for (int r = 0; r < reps; r++) exp_q.push_back(sym);
      end
    end
  endfunction

  task automatic check_stream(input string name, input int k);
    int n = (got[k].size() > exp_q.size()) ? got[k].size() : exp_q.size();
    int mism = -1;
    total++;
    for (int i = 0; i < n; i++) begin
      if (i >= got[k].size() || i >= exp_q.size() || got[k][i] != exp_q[i]) begin
        mism = i;
        break;
      end
    end
    if (mism >= 0) begin
      bad++;
      $display("FAIL %s: symbol %0d got %0d expected %0d (lengths got %0d expected %0d)", name, mism,
               (mism < got[k].size()) ? int'(got[k][mism]) : -1,
               (mism < exp_q.size()) ? int'(exp_q[mism]) : -1, got[k].size(), exp_q.size());
    end
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    #1;
    while (!rdy[k] && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[k]) begin
      total++;
      bad++;
      $display("FAIL wait_ready dut%0d: ready got 0 after %0d cycles expected 1", k, n);
    end
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (en[k] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (en[k]) begin
      total++;
      bad++;
      $display("FAIL wait_idle dut%0d: tx_en got 1 after %0d cycles expected 0", k, n);
    end
  endtask

  // hole: valid withheld at the boundary after that many bytes; rst_at: reset after that many bytes.
  task automatic send_frame(input int k, input int nb, input int hole, input int rst_at,
                            input logic [7:0][7:0] b);
    for (int i = 0; i < nb; i++) begin
      v[k] = 1'b1; so[k] = (i == 0); eo[k] = (i == nb - 1); d[k] = b[i];
      wait_ready(k);
      @(negedge clk);
      if (rst_at == i + 1) begin
        v[k] = 1'b0; so[k] = 1'b0; eo[k] = 1'b0;
        rst_n = 1'b0;
        break;
      end
      if (hole == i + 1) begin
        v[k] = 1'b0; so[k] = 1'b0; eo[k] = 1'b0;
        wait_ready(k);
        @(negedge clk);
      end
    end
    v[k] = 1'b0; so[k] = 1'b0; eo[k] = 1'b0;
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int w = (t.k == 1) ? 4 : 2;
    int u0;
    spd = !t.slow;
    @(negedge clk);
    got[t.k].delete();
    u0 = uc[t.k];
    send_frame(t.k, t.nb, t.hole, 0, t.b);
    wait_idle(t.k);
    repeat (ipg_len(w, t.slow) + 4) @(negedge clk);
    exp_q.delete();
    build_exp(w, t.slow, (t.hole >= 0) ? t.hole : t.nb, t.b);
    if (t.ur_exp == 0) exp_cnt[t.k] = (exp_cnt[t.k] + 1) & 'hFFFF;
    chk($sformatf("v%0d tx_en_len", idx), got[t.k].size(), t.en_len);
    check_stream($sformatf("v%0d stream", idx), t.k);
    chk($sformatf("v%0d underrun_pulses", idx), uc[t.k] - u0, t.ur_exp);
    chk($sformatf("v%0d frame_cnt", idx), (t.k == 0) ? fc0 : fc1, exp_cnt[t.k]);
  endtask

  initial begin
    vec_t            t2;
    logic [7:0][7:0] b4;
    int              u0;

    vt[0] = '{k:0, slow:0, nb:4, hole:-1, en_len:48,  ur_exp:0, b:64'h0403_0201};
    vt[1] = '{k:0, slow:1, nb:4, hole:-1, en_len:480, ur_exp:0, b:64'h0403_0201};
    vt[2] = '{k:1, slow:0, nb:1, hole:-1, en_len:18,  ur_exp:0, b:64'hA5};
    vt[3] = '{k:0, slow:0, nb:6, hole:2,  en_len:40,  ur_exp:1, b:64'h6655_4433_2211};
    vt[4] = '{k:1, slow:1, nb:3, hole:-1, en_len:220, ur_exp:0, b:64'h0F_F03C};
    for (int r = 5; r < 14; r++) begin
      int w, sent;
      vt[r].k    = int'($urandom_range(0, 1));
      vt[r].slow = ($urandom_range(0, 3) == 0);
      vt[r].nb   = int'($urandom_range(1, 6));
      vt[r].hole = (vt[r].nb >= 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, vt[r].nb - 1)) : -1;
      for (int i = 0; i < 8; i++) vt[r].b[i] = 8'($urandom);
      w    = (vt[r].k == 1) ? 4 : 2;
      sent = (vt[r].hole >= 0) ? vt[r].hole : vt[r].nb;
      vt[r].en_len = (8 + sent) * (8 / w) * (vt[r].slow ? 10 : 1);
      vt[r].ur_exp = (vt[r].hole >= 0) ? 1 : 0;
    end

    rst_n = 1'b0; spd = 1'b1; v = 2'b11; so = '0; eo = '0; d = '0;
    uc[0] = 0; uc[1] = 0; low_run[0] = 0; low_run[1] = 0; exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", rdy, 0);
    chk("reset tx_en", en, 0);
    chk("reset txd2", txd2, 0);
    chk("reset txd4", txd4, 0);
    chk("reset frame_cnt", fc0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset ready non-sop", rdy, 3);
    @(negedge clk);
    v = '0;

    for (int i = 0; i < 14; i++) run_vec(vt[i], i);

    // Speed changes mid-frame; this frame stays at 100, the next one runs at 10.
    b4 = 64'h0403_0201;
    spd = 1'b1;
    @(negedge clk);
    got[0].delete();
    fork
      send_frame(0, 4, -1, 0, b4);
      begin repeat (20) @(negedge clk); spd = 1'b0; end
    join
    wait_idle(0);
    repeat (60) @(negedge clk);
    exp_q.delete();
    build_exp(2, 1'b0, 4, b4);
    check_stream("speed_toggle stream", 0);
    exp_cnt[0] = (exp_cnt[0] + 1) & 'hFFFF;
    chk("speed_toggle frame_cnt", fc0, exp_cnt[0]);
    t2 = '{k:0, slow:1, nb:2, hole:-1, en_len:400, ur_exp:0, b:64'hBEEF};
    run_vec(t2, 100);

    // Reset while the third byte is in flight.
    spd = 1'b1;
    @(negedge clk);
    u0 = uc[0];
    send_frame(0, 6, -1, 3, 64'h6655_4433_2211);
    #1;
    chk("midreset tx_en", en, 0);
    chk("midreset txd2", txd2, 0);
    chk("midreset underrun", ur, 0);
    chk("midreset frame_cnt", fc0, 0);
    v[0] = 1'b1; so[0] = 1'b0;
    #1;
    chk("midreset ready", rdy[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after midreset ready", rdy[0], 1);
    @(negedge clk);
    v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("midreset no underrun", uc[0] - u0, 0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;

    // Counter wrap with back-to-back frames.
    force dut2.frame_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut2.frame_cnt_q;
    @(negedge clk);
    chk("preset frame_cnt", fc0, 'hFFFE);
    gaps[0].delete(); fcs[0].delete(); got[0].delete(); exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      logic [7:0][7:0] bb = '0;
      bb[0] = 8'(8'h30 + f);
      bb[1] = 8'(8'hC0 + f);
      send_frame(0, 2, -1, 0, bb);
      build_exp(2, 1'b0, 2, bb);
    end
    wait_idle(0);
    repeat (52) @(negedge clk);
    check_stream("b2b stream", 0);
    chk("b2b frame_cnt wrapped", fc0, 1);
    chk("b2b frame starts", gaps[0].size(), 3);
    if (gaps[0].size() >= 3) begin
      chk("b2b ipg_gap 1", gaps[0][1], IPG * 4 + 1);
      chk("b2b ipg_gap 2", gaps[0][2], IPG * 4 + 1);
      chk("b2b cnt at frame 2", fcs[0][1], 'hFFFF);
      chk("b2b cnt at frame 3", fcs[0][2], 0);
    end

    chk("txd zero while tx_en low", zviol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
